// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder controller.
package serial_adder_pkg;

  // Operand width used when the instantiating unit does not override it
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Controller state encodings
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Bit-position counter width; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bit_full_adder.sv
// One-bit full adder cell shared across every bit position of the serial add.
module bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic p;
  logic g_ab;
  logic g_pc;

  // First half adder: propagate and generate from the operand bits
  assign p    = a ^ b;
  assign g_ab = a & b;

  // Second half adder folds in the incoming carry
  assign s    = p ^ cin;
  assign g_pc = p & cin;

  // Carry out from either half-adder stage
  assign co   = g_ab | g_pc;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial addition controller: accepts an operand pair, walks it LSB-first
// through a single full-adder cell with a registered carry, then reports
// sum/cout with a one-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done
);

  localparam int unsigned      CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Upper WIDTH-1 result bits collected so far; the LSB slot would only ever
  // shift out, so it is not stored.
  logic [WIDTH-1:1] res_sr;
  logic [WIDTH-1:0] res_nxt_c;
  logic             carry;
  logic             cell_s;
  logic             cell_co;
  logic             accept_c;
  logic             last_c;

  assign accept_c  = (state == IDLE) && start_valid && start_ready;
  assign last_c    = (state == ADD) && (count == LAST);
  assign res_nxt_c = {cell_s, res_sr};

  // Shared adder cell fed from the operand LSBs and the carry flop
  bit_full_adder u_cell (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (cell_s),
    .co  (cell_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = ADD;
      ADD:     if (last_c)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shift registers, carry flop, partial result and bit counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
    end else if (accept_c) begin
      a_sr   <= a;
      b_sr   <= b;
      carry  <= 1'b0;
      count  <= '0;
    end else if (state == ADD) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= res_nxt_c[WIDTH-1:1];
      carry  <= cell_co;
      // Hold at the last position so the counter never wraps mid-operation
      if (!last_c) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Registered handshake, status and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_ready <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sum         <= '0;
      cout        <= 1'b0;
    end else begin
      start_ready <= (state_nxt == IDLE);
      busy        <= (state_nxt != IDLE);
      done        <= last_c;
      if (last_c) begin
        sum  <= res_nxt_c;
        cout <= cell_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: the driver pushes the arithmetic
// result a+b on every accepted handshake; a monitor pops on every done pulse.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy;
  logic [W-1:0] sum;
  logic         cout;
  logic         done;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           edge_no;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic prev_done = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a_i),
    .b           (b_i),
    .busy        (busy),
    .sum         (sum),
    .cout        (cout),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding addition
  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("done_single_cycle", prev_done, 1'b0);
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", sum, e.sum);
        chk("cout", cout, e.cout);
        chk("done_latency", 64'(cyc - e.edge_no), W);
        chk("busy_in_done", busy, 1'b1);
        chk("ready_in_done", start_ready, 1'b0);
      end
    end
    prev_done = done;
  end

  // Present an operand pair until accepted; called and returns at a negedge
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, output int e);
    logic [W:0] r;
    bit         ok;
    exp_t       x;
    ok = 1'b0;
    e  = -1;
    a_i = av;
    b_i = bv;
    start_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (start_ready) begin
        e = cyc + 1;
        r = {1'b0, av} + {1'b0, bv};
        x.sum = r[W-1:0];
        x.cout = r[W];
        x.edge_no = e;
        q.push_back(x);
        ok = 1'b1;
        @(posedge clk);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: got no start_ready, expected accept within 60 cycles");
    end
  endtask

  task automatic idle_req();
    start_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d outstanding results, expected 0", q.size());
    end
  endtask

  initial begin
    int e1, e2, e3;
    rst_n = 1'b0;
    start_valid = 1'b0;
    a_i = '0;
    b_i = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", start_ready, 1);

    // Basic addition and handshake
    issue(8'h5A, 8'h3C, e1);
    chk("ready_low_after_accept", start_ready, 0);
    chk("busy_after_accept", busy, 1);
    idle_req();
    wait_drain();

    // Carry out of the top bit, then zero operands
    issue(8'hFF, 8'h01, e1);
    idle_req();
    wait_drain();
    issue(8'h00, 8'h00, e1);
    idle_req();
    wait_drain();
    chk("sum_held", sum, 8'h00);

    // New request while busy must be ignored
    issue(8'h80, 8'h80, e1);
    idle_req();
    @(negedge clk);
    a_i = 8'h11;
    b_i = 8'h22;
    start_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ready_low_in_add", start_ready, 0);
      @(negedge clk);
    end
    idle_req();
    wait_drain();
    chk("cout_held", cout, 1);

    // Continuous valid: accepts spaced by WIDTH+2
    issue(8'h01, 8'h02, e1);
    issue(8'h7F, 8'h01, e2);
    issue(8'hF0, 8'h20, e3);
    idle_req();
    chk("accept_spacing_1", 64'(e2 - e1), W + 2);
    chk("accept_spacing_2", 64'(e3 - e2), W + 2);
    wait_drain();

    // Reset in the middle of an addition
    issue(8'hAA, 8'h55, e1);
    idle_req();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", start_ready, 1);
    repeat (W + 2) begin
      chk("midrst_no_done", done, 0);
      @(negedge clk);
    end
    issue(8'h0F, 8'h01, e1);
    idle_req();
    wait_drain();

    // Randomized sweep, valid sometimes held across results
    for (int n = 0; n < 300; n++) begin
      issue(W'($urandom), W'($urandom), e1);
      if ($urandom_range(1) == 0) idle_req();
      else if (n % 7 == 0) begin
        idle_req();
        repeat ($urandom_range(3)) @(negedge clk);
      end
    end
    idle_req();
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial addition controller that shares a single 1-bit adder cell across all bit positions of two WIDTH-bit operands.
- Accepts an operand pair through a valid/ready handshake.
- Shifts the operands LSB-first through the cell for WIDTH cycles, with a registered carry.
- Reports sum and carry-out with a one-cycle done pulse.
- Sits between a requesting unit and the shared adder cell; it replaces a WIDTH-wide parallel adder where area matters more than latency.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), bit-position counter width; derived, never overridden.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
start_valid  input  1  requester presents an operand pair.
start_ready  output  1  controller can accept; high only in IDLE.
a  input  WIDTH  operand A; sampled only on the accept edge.
b  input  WIDTH  operand B; sampled only on the accept edge.
busy  output  1  high in ADD and DONE.
sum  output  WIDTH  result of the last completed addition; held until the next completion.
cout  output  1  carry-out of the last completed addition; held with sum.
done  output  1  one-cycle pulse: sum and cout are newly valid.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE, count=0, carry=0, operand shift registers=0.
  - sum=0, cout=0, done=0, busy=0.
  - start_ready=1 from the first edge after rst_n goes high.
- States: IDLE, ADD, DONE. Encodings are defined in the package.
- IDLE:
  - start_ready=1, busy=0, done=0.
  - On an edge with start_valid=1: a_sr<=a, b_sr<=b, carry<=0, count<=0, state<=ADD (accept edge E).
  - With start_valid=0 the controller stays in IDLE and a/b are ignored.
- ADD (edges E+1 .. E+WIDTH):
  - Cell inputs are a_sr[0], b_sr[0] and carry.
  - Cell outputs are s and co, where s = a^b^cin and co = a&b | cin&(a^b).
  - Each edge: a_sr and b_sr shift right by 1 with zero fill; res_sr<={s, res_sr[WIDTH-1:1]}; carry<=co; count<=count+1.
  - On the edge where count==WIDTH-1: sum<={s, res_sr[WIDTH-1:1]}, cout<=co, state<=DONE.
  - start_ready=0; start_valid is ignored, no queuing.
- DONE (one cycle):
  - done=1 and busy=1; sum and cout are already updated.
  - Next edge: state<=IDLE, done<=0.
- Latency and throughput:
  - done is high in the cycle following edge E+WIDTH.
  - The next accept is possible at edge E+WIDTH+2.
  - Maximum throughput is one addition per WIDTH+2 cycles.
- Arithmetic: {cout,sum} == a+b, computed as unsigned WIDTH+1-bit. No overflow flag.
- Boundary conditions:
  - All-ones + 1 gives sum=0, cout=1.
  - 0+0 still takes the full WIDTH cycles and pulses done.
  - count stops at WIDTH-1 and never wraps within an operation.
  - Operand inputs changing during ADD have no effect.
- Reset mid-operation:
  - Aborts immediately and returns to IDLE with all reset values, including sum=0 and cout=0.
  - No done pulse is produced for the aborted operation.
- start_valid held high continuously: one operand pair is accepted each time IDLE is reached. The requester must update a/b after each accept.

Decomposition:
- Package serial_adder_pkg holds:
  - State enum: IDLE=2'd0, ADD=2'd1, DONE=2'd2.
  - Default WIDTH constant.
  - Helper for the count width.
- One sub-module, bit_full_adder, the 1-bit adder cell:
  - Purely combinational.
  - Built from two half-adder stages plus an OR of the carries.
  - Instantiated once; no other logic inside it.
- The controller holds the FSM, counter, shift registers, carry flop and output registers. Expected size is 150-250 lines.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, pulse start_valid -> start_ready drops after the accept edge; done pulses exactly 9 cycles after the accept edge; sum=0x96, cout=0.
2. a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0x00, b=0x00 -> sum=0x00, cout=0, done still pulses after full latency.
3. During ADD, drive start_valid=1 with a=0x11, b=0x22 -> start_ready stays 0 and the in-flight result is unaffected: 0x80+0x80 gives sum=0x00, cout=1.
4. start_valid held high for three operand pairs (0x01+0x02, 0x7F+0x01, 0xF0+0x20) -> accepts spaced exactly 10 cycles apart; results 0x03/0, 0x80/0, 0x10/1.
5. Reset mid-operation: assert rst_n=0 four cycles after accepting 0xAA+0x55 -> next edge gives IDLE, sum=0, cout=0, no done pulse. A following 0x0F+0x01 gives 0x10/0.
6. WIDTH=4 build, a=0xF, b=0xF -> done 5 cycles after accept; sum=0xE, cout=1. A random sweep of 1000 pairs against a+b reports zero mismatches.
